debounce_scan_ctrl: RTL

//   Shared-timer debounce scheduler for N push-buttons.
//   - One prescaler produces a sample tick. On each tick an FSM scans the buttons, one per clock.
//   - Each button's stability counter is updated; a debounced level is flipped once the input
//     has held its new value for STABLE_TICKS consecutive ticks.
//   - Each level change is reported as a press/release event through a single-entry

---
 rtl/debounce_scan_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/debounce_scan_ctrl.sv
`timescale 1ns/1ps
// debounce_scan_ctrl
// Debounces N_BTN raw buttons with one shared sample-tick prescaler. On each
// tick an FSM walks the buttons one per clock and updates a per-button
// stability counter. When a button's level flips, a press/release event goes
// out through a single-entry valid/ready slot.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for the next sample tick, o_busy=0
//   SCAN  | processing button idx this cycle, o_busy=1
//
module debounce_scan_ctrl #(
   parameter int N_BTN        = 4,
   parameter int IDX_W        = 2,
   parameter int TICK_DIV     = 100000,
   parameter int STABLE_TICKS = 10,
   parameter int CNT_W        = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] i_btn,
   output logic [N_BTN-1:0] o_level,
   output logic             o_evt_valid,
   input  logic             i_evt_ready,
   output logic [IDX_W-1:0] o_evt_id,
   output logic             o_evt_press,
   output logic             o_overflow,
   output logic             o_busy
);

   localparam int               TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_TICKS - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_BTN - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   // Synchronizer
   logic [N_BTN-1:0]  sync1_q, sync1_d;
   logic [N_BTN-1:0]  sync2_q, sync2_d;

   // Prescaler and scan FSM
   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
   logic              tick;
   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;

   // Debounce state
   logic [N_BTN-1:0]  level_q, level_d;
   logic [CNT_W-1:0]  cnt_q [N_BTN];
   logic [CNT_W-1:0]  cnt_d [N_BTN];
   logic              raise;
   logic [IDX_W-1:0]  raise_id;
   logic              raise_press;

   // Event slot
   logic              evt_valid_q, evt_valid_d;
   logic [IDX_W-1:0]  evt_id_q, evt_id_d;
   logic              evt_press_q, evt_press_d;
   logic              ovf_q, ovf_d;
   logic              xfer;

   // Two-flop synchronizer inputs; the scan only ever looks at sync2_q.
   always_comb begin
      sync1_d = i_btn;
      sync2_d = sync1_q;
   end

   // Free-running prescaler, tick in the last count of each period.
   always_comb begin
      tick       = (tick_cnt_q == TICK_LAST);
      tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
   end

   // Scan FSM: one tick starts a pass over every button, one per clock.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (tick) begin
               state_d = ST_SCAN;
               idx_d   = '0;
            end
         end
         ST_SCAN: begin
            if (idx_q == IDX_LAST) begin
               state_d = ST_IDLE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // Per-button stability counting; only the button under idx is touched.
   always_comb begin
      level_d     = level_q;
      raise       = 1'b0;
      raise_id    = '0;
      raise_press = 1'b0;
      for (int k = 0; k < N_BTN; k++) begin
         cnt_d[k] = cnt_q[k];
      end
      if (state_q == ST_SCAN) begin
         for (int k = 0; k < N_BTN; k++) begin
            if (idx_q == IDX_W'(k)) begin
               if (sync2_q[k] == level_q[k]) begin
                  cnt_d[k] = '0;
               end else if (cnt_q[k] == CNT_LAST) begin
                  // Held the new value for STABLE_TICKS samples: flip and report.
                  level_d[k]  = sync2_q[k];
                  cnt_d[k]    = '0;
                  raise       = 1'b1;
                  raise_id    = IDX_W'(k);
                  raise_press = sync2_q[k];
               end else begin
                  cnt_d[k] = cnt_q[k] + CNT_W'(1);
               end
            end
         end
      end
   end

   // Event slot: a transfer in the same cycle frees room for a new event,
   // otherwise a new event against a full slot is dropped and flagged.
   always_comb begin
      xfer        = evt_valid_q & i_evt_ready;
      evt_valid_d = evt_valid_q;
      evt_id_d    = evt_id_q;
      evt_press_d = evt_press_q;
      ovf_d       = ovf_q;
      if (raise) begin
         if (!evt_valid_q || i_evt_ready) begin
            evt_valid_d = 1'b1;
            evt_id_d    = raise_id;
            evt_press_d = raise_press;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (xfer) begin
         evt_valid_d = 1'b0;
      end
   end

   // State registers; reset abandons any scan in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         tick_cnt_q  <= '0;
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         level_q     <= '0;
         evt_valid_q <= 1'b0;
         evt_id_q    <= '0;
         evt_press_q <= 1'b0;
         ovf_q       <= 1'b0;
         for (int k = 0; k < N_BTN; k++) begin
            cnt_q[k] <= '0;
         end
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         tick_cnt_q  <= tick_cnt_d;
         state_q     <= state_d;
         idx_q       <= idx_d;
         level_q     <= level_d;
         evt_valid_q <= evt_valid_d;
         evt_id_q    <= evt_id_d;
         evt_press_q <= evt_press_d;
         ovf_q       <= ovf_d;
         for (int k = 0; k < N_BTN; k++) begin
            cnt_q[k] <= cnt_d[k];
         end
      end
   end

   assign o_level     = level_q;
   assign o_evt_valid = evt_valid_q;
   assign o_evt_id    = evt_id_q;
   assign o_evt_press = evt_press_q;
   assign o_overflow  = ovf_q;
   assign o_busy      = (state_q == ST_SCAN);

endmodule
